// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: blank pattern and hex-to-segment encoding.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment decoder.
module ssd_seg7_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  assign seg_c = seg7(hex);

endmodule

// File: rtl/ssd_mux_controller.sv
// Multiplexed seven-segment display scanner with frame-synchronous input shadowing,
// leading-zero blanking, per-digit blink and decimal point.
module ssd_mux_controller
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [NUM_DIGITS-1:0]     dp_en,
  input  logic [NUM_DIGITS-1:0]     blink_en,
  input  logic                      lz_blank,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic [6:0]                ssdOut,
  output logic                      dp_n
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [FRM_W-1:0]          frm;
  logic                      phase;
  logic                      init;

  logic [4*NUM_DIGITS-1:0]   sh_value;
  logic [NUM_DIGITS-1:0]     sh_digit_en;
  logic [NUM_DIGITS-1:0]     sh_dp_en;
  logic [NUM_DIGITS-1:0]     sh_blink_en;
  logic                      sh_lz;

  logic                      tick_c;
  logic                      frame_end_c;
  logic [NUM_DIGITS-1:0]     upper_zero_c;
  logic                      zero_acc_c;
  logic                      blank_c;
  logic [3:0]                nibble_c;
  logic [6:0]                seg_c;

  assign tick_c      = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end_c = tick_c && (idx == IDX_W'(NUM_DIGITS - 1));

  // Scan timing, blink phase and frame-aligned input capture; the cycle after
  // reset only captures so that digit 0 gets a full dwell with real data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      frm         <= '0;
      phase       <= 1'b0;
      init        <= 1'b1;
      sh_value    <= '0;
      sh_digit_en <= '0;
      sh_dp_en    <= '0;
      sh_blink_en <= '0;
      sh_lz       <= 1'b0;
    end else if (init) begin
      init        <= 1'b0;
      sh_value    <= value;
      sh_digit_en <= digit_en;
      sh_dp_en    <= dp_en;
      sh_blink_en <= blink_en;
      sh_lz       <= lz_blank;
    end else begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
      if (tick_c) begin
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end
      if (frame_end_c) begin
        sh_value    <= value;
        sh_digit_en <= digit_en;
        sh_dp_en    <= dp_en;
        sh_blink_en <= blink_en;
        sh_lz       <= lz_blank;
        if (frm == FRM_W'(BLINK_FRAMES - 1)) begin
          frm   <= '0;
          phase <= ~phase;
        end else begin
          frm <= frm + FRM_W'(1);
        end
      end
    end
  end

  // upper_zero_c[i]: shadow nibbles i..NUM_DIGITS-1 are all zero
  always_comb begin
    upper_zero_c = '0;
    zero_acc_c   = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_acc_c      = zero_acc_c & (sh_value[4*i +: 4] == 4'h0);
      upper_zero_c[i] = zero_acc_c;
    end
  end

  assign nibble_c = sh_value[int'(idx)*4 +: 4];
  assign blank_c  = !sh_digit_en[idx]
                 || (sh_lz && (idx != '0) && upper_zero_c[idx])
                 || (phase && sh_blink_en[idx]);

  ssd_seg7_decoder u_dec (
    .hex   (nibble_c),
    .seg_c (seg_c)
  );

  always_ff @(posedge clk) begin
    if (reset || blank_c) begin
      anode  <= '1;
      ssdOut <= SEG_BLANK;
      dp_n   <= 1'b1;
    end else begin
      anode  <= ~(NUM_DIGITS'(1) << idx);
      ssdOut <= seg_c;
      dp_n   <= ~sh_dp_en[idx];
    end
  end

endmodule

// File: tb/tb_ssd_mux_controller.sv
// Bench for ssd_mux_controller: directed scenarios and random input churn checked
// every cycle against a time-based model of the display.
module tb_ssd_mux_controller;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BF = 2;
  localparam int NR = N * RD;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp_en;
  logic [3:0]  blink_en;
  logic        lz_blank;
  logic [3:0]  anode;
  logic [6:0]  ssdOut;
  logic        dp_n;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  en;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic        lz;
  } snap_t;

  snap_t      snaps [4];
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int   k;
  bit   in_rst;
  int   checks;
  int   errors;

  ssd_mux_controller #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .digit_en (digit_en),
    .dp_en    (dp_en),
    .blink_en (blink_en),
    .lz_blank (lz_blank),
    .anode    (anode),
    .ssdOut   (ssdOut),
    .dp_n     (dp_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge k (k=0 is the first edge with reset low) shows slot (k-1)/RD using the
  // inputs present at the frame-start edge of that slot's frame.
  task automatic step();
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    @(posedge clk);
    if (reset) begin
      in_rst = 1'b1;
      k      = -1;
    end else begin
      in_rst = 1'b0;
      k++;
      if (k % NR == 0) snaps[(k / NR) % 4] = '{value, digit_en, dp_en, blink_en, lz_blank};
    end
    #1;
    ea = 4'hF;
    es = 7'h7F;
    ed = 1'b1;
    if (!in_rst && k > 0) begin
      int    s, d, f;
      bit    ph, blank;
      snap_t sn;
      s  = (k - 1) / RD;
      d  = s % N;
      f  = s / N;
      sn = snaps[f % 4];
      ph = ((f / BF) % 2) == 1;
      blank = !sn.en[d] || (sn.lz && d > 0 && ((sn.v >> (4 * d)) == 16'h0)) || (ph && sn.bl[d]);
      if (!blank) begin
        ea = ~(4'b0001 << d);
        es = seg_tab[sn.v[4*d +: 4]];
        ed = ~sn.dp[d];
      end
    end
    checks++;
    assert (anode === ea) else begin
      errors++;
      $error("FAIL anode k=%0d rst=%0d got %b exp %b", k, in_rst, anode, ea);
    end
    checks++;
    assert (ssdOut === es) else begin
      errors++;
      $error("FAIL ssdOut k=%0d rst=%0d got %h exp %h", k, in_rst, ssdOut, es);
    end
    checks++;
    assert (dp_n === ed) else begin
      errors++;
      $error("FAIL dp_n k=%0d rst=%0d got %b exp %b", k, in_rst, dp_n, ed);
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    k        = -1;
    in_rst   = 1'b1;
    reset    = 1'b1;
    value    = 16'h0;
    digit_en = 4'h0;
    dp_en    = 4'h0;
    blink_en = 4'h0;
    lz_blank = 1'b0;
    run(3);

    // Plain scan of 1234
    value    = 16'h1234;
    digit_en = 4'hF;
    reset    = 1'b0;
    run(3 * NR + 1);

    // Tear-free update mid-frame
    value = 16'h1111;
    run(2 * NR);
    run(6);
    value = 16'h2222;
    run(2 * NR);

    // Leading-zero blanking
    value    = 16'h0050;
    lz_blank = 1'b1;
    run(2 * NR);
    value = 16'h0000;
    run(2 * NR);

    // Decimal point with a disabled digit, then all enabled
    lz_blank = 1'b0;
    value    = 16'h1234;
    dp_en    = 4'b0100;
    digit_en = 4'b1011;
    run(2 * NR);
    digit_en = 4'hF;
    run(2 * NR);

    // Blink on digit 0
    dp_en    = 4'h0;
    blink_en = 4'b0001;
    run(8 * NR);

    // Reset while digit 2 is on display
    for (int i = 0; i < NR && !(k > 0 && ((k - 1) / RD) % N == 2); i++) step();
    reset = 1'b1;
    step();
    checks++;
    assert (anode === 4'hF && ssdOut === 7'h7F && dp_n === 1'b1) else begin
      errors++;
      $error("FAIL midreset got anode=%b seg=%h dp=%b exp 1111/7f/1", anode, ssdOut, dp_n);
    end
    step();
    reset    = 1'b0;
    blink_en = 4'h0;
    run(NR + 2);
    checks++;
    assert (anode === 4'b1110) else begin
      errors++;
      $error("FAIL restart got anode=%b exp 1110", anode);
    end

    // Random churn on all inputs
    for (int i = 0; i < 40 * NR; i++) begin
      step();
      if ($urandom_range(7) == 0) value    = 16'($urandom);
      if ($urandom_range(15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(15) == 0) dp_en    = 4'($urandom);
      if ($urandom_range(15) == 0) blink_en = 4'($urandom);
      if ($urandom_range(15) == 0) lz_blank = 1'($urandom);
      if ($urandom_range(255) == 0) reset = 1'b1;
      else reset = 1'b0;
    end
    reset = 1'b0;
    run(2 * NR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_mux_controller.md
SSD_MUX_CONTROLLER -- requirements
Module: ssd_mux_controller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot, minimum 2.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64: full scan frames per blink half-period, minimum 1.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port value, input, 4*NUM_DIGITS: hex nibbles; nibble i ([4i+3:4i]) shows on digit i, where digit 0 is rightmost.
REQ-007 SHALL have port digit_en, input, NUM_DIGITS: per-digit enable; 0 blanks the digit.
REQ-008 SHALL have port dp_en, input, NUM_DIGITS: per-digit decimal point on.
REQ-009 SHALL have port blink_en, input, NUM_DIGITS: per-digit blink select.
REQ-010 SHALL have port lz_blank, input, 1: leading-zero blanking mode.
REQ-011 SHALL have port anode, output, NUM_DIGITS: active-low one-hot digit select.
REQ-012 SHALL have port ssdOut, output, 7: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-013 SHALL have port dp_n, output, 1: active-low decimal point.

Function
REQ-014 SHALL keep a refresh counter running 0..REFRESH_DIV-1 that wraps to 0; a tick is the cycle in which it equals REFRESH_DIV-1.
REQ-015 SHALL advance digit index idx by one on each tick, wrapping from NUM_DIGITS-1 to 0; a frame ends on the tick where idx wraps.
REQ-016 SHALL capture value, digit_en, dp_en, blink_en and lz_blank into shadow registers at each frame end, and in the first cycle after reset deasserts; inputs SHALL NOT affect the display at any other time, so no tearing occurs mid-frame.
REQ-017 SHALL register all outputs; anode, ssdOut and dp_n for a new idx SHALL change together one cycle after the tick.
REQ-018 SHALL drive anode with bit idx = 0 and all other bits = 1 while the digit is visible; when the digit is blanked, anode SHALL be all ones.
REQ-019 SHALL blank digit i when its shadow digit_en is 0.
REQ-020 SHALL blank digit i (i>0) when shadow lz_blank = 1 and shadow nibbles i..NUM_DIGITS-1 are all zero; digit 0 SHALL never be lz-blanked.
REQ-021 SHALL keep a frame counter and a blink phase bit; phase SHALL toggle when BLINK_FRAMES frames have completed, and while phase = 1, digits with shadow blink_en = 1 SHALL be blanked.
REQ-022 SHALL encode hex 0-F with standard active-low segment patterns; a blanked digit SHALL output ssdOut = 7'h7F and dp_n = 1.
REQ-023 SHALL drive dp_n = ~dp_en[idx] for a visible digit; dp SHALL follow the same blanking rules as the segments.
REQ-024 SHALL make an input change visible no later than one full frame plus one cycle after the next frame end.

Reset
REQ-025 SHALL, while reset is high, set the refresh counter, idx, frame counter, blink phase and all shadow registers to 0.
REQ-026 SHALL, while reset is high, drive anode all ones, ssdOut = 7'h7F and dp_n = 1.
REQ-027 SHALL apply reset asserted mid-frame on the next clk edge, with no partial digit output.

Structure
REQ-028 SHALL place the seg7 encoding function and the SEG_BLANK = 7'h7F constant in shared package ssd_pkg.
REQ-029 SHALL implement hex-to-segment decode as combinational sub-module ssd_seg7_decoder, instantiated once.

Verification
Benches use NUM_DIGITS=4, REFRESH_DIV=4 and BLINK_FRAMES=2 unless stated.
REQ-030 SHALL cover scan: value=16'h1234, all enables on -> anode cycles 1110,1101,1011,0111 with a 4-cycle dwell per digit; ssdOut shows 4,3,2,1 respectively (7'h19, 7'h30, 7'h24, 7'h79).
REQ-031 SHALL cover leading-zero blanking: value=16'h0050, lz_blank=1 -> digits 3 and 2 blank (anode 1111, ssdOut 7'h7F); digit 1 = 5, digit 0 = 0; value=0 -> only digit 0 shows 0.
REQ-032 SHALL cover tear-free update: value changes from 16'h1111 to 16'h2222 mid-frame -> the rest of the frame still shows 1 on every digit, and the next frame shows 2.
REQ-033 SHALL cover blink: blink_en=4'b0001 -> digit 0 visible for 2 frames, blank for 2 frames, repeating; other digits are always visible.
REQ-034 SHALL cover reset mid-frame at idx=2 -> the next cycle gives anode=1111, ssdOut=7'h7F, dp_n=1, and the scan restarts at digit 0 after release.
REQ-035 SHALL cover decimal point and digit enable: dp_en=4'b0100, digit_en=4'b1011 -> dp_n=0 only never (digit 2 is disabled); with digit_en=4'hF, dp_n=0 only during the digit-2 slot.
